// File: rtl/alu_cntrl_decoder.sv
// RV32I instruction to AluCntrl decoder with a registered output stage and a
// skid register, plus a saturating count of accepted illegal encodings.
module alu_cntrl_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_cntrl,
    output logic             src_a_pc,
    output logic             src_b_imm,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [3:0] ALU_ADD      = 4'd0;
    localparam logic [3:0] ALU_SUB      = 4'd1;
    localparam logic [3:0] ALU_SHIFT_LL = 4'd2;
    localparam logic [3:0] ALU_SHIFT_RL = 4'd3;
    localparam logic [3:0] ALU_SHIFT_RA = 4'd4;
    localparam logic [3:0] ALU_SET_LT   = 4'd5;
    localparam logic [3:0] ALU_SET_LTU  = 4'd6;
    localparam logic [3:0] ALU_XOR      = 4'd7;
    localparam logic [3:0] ALU_OR       = 4'd8;
    localparam logic [3:0] ALU_AND      = 4'd9;
    localparam logic [3:0] ALU_PASS_B   = 4'd11;
    localparam logic [3:0] ALU_PC_INC   = 4'd12;

    typedef struct packed {
        logic [3:0] alu;
        logic       a_pc;
        logic       b_imm;
        logic       ill;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = instr[14:12];
        f7 = instr[31:25];
        d  = '{alu: ALU_ADD, a_pc: 1'b0, b_imm: 1'b0, ill: 1'b0};
        case (instr[6:0])
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d.alu = ALU_ADD;
                        3'b001:  d.alu = ALU_SHIFT_LL;
                        3'b010:  d.alu = ALU_SET_LT;
                        3'b011:  d.alu = ALU_SET_LTU;
                        3'b100:  d.alu = ALU_XOR;
                        3'b101:  d.alu = ALU_SHIFT_RL;
                        3'b110:  d.alu = ALU_OR;
                        3'b111:  d.alu = ALU_AND;
                        default: d.ill = 1'b1;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d.alu = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d.alu = ALU_SHIFT_RA;
                end else begin
                    d.ill = 1'b1;
                end
            end
            7'b0010011: begin
                d.b_imm = 1'b1;
                case (f3)
                    3'b000:  d.alu = ALU_ADD;
                    3'b010:  d.alu = ALU_SET_LT;
                    3'b011:  d.alu = ALU_SET_LTU;
                    3'b100:  d.alu = ALU_XOR;
                    3'b110:  d.alu = ALU_OR;
                    3'b111:  d.alu = ALU_AND;
                    3'b001:  begin
                        d.alu = ALU_SHIFT_LL;
                        d.ill = (f7 != 7'b0000000);
                    end
                    3'b101:  begin
                        if (f7 == 7'b0000000) begin
                            d.alu = ALU_SHIFT_RL;
                        end else if (f7 == 7'b0100000) begin
                            d.alu = ALU_SHIFT_RA;
                        end else begin
                            d.ill = 1'b1;
                        end
                    end
                    default: d.ill = 1'b1;
                endcase
            end
            7'b0110111: begin
                d.alu   = ALU_PASS_B;
                d.b_imm = 1'b1;
            end
            7'b0010111: begin
                d.a_pc  = 1'b1;
                d.b_imm = 1'b1;
            end
            7'b1101111: begin
                d.alu  = ALU_PC_INC;
                d.a_pc = 1'b1;
            end
            7'b1100111: begin
                d.alu  = ALU_PC_INC;
                d.a_pc = 1'b1;
                d.ill  = (f3 != 3'b000);
            end
            7'b0000011, 7'b0100011: d.b_imm = 1'b1;
            7'b1100011: begin
                case (f3[2:1])
                    2'b00:   d.alu = ALU_SUB;
                    2'b10:   d.alu = ALU_SET_LT;
                    2'b11:   d.alu = ALU_SET_LTU;
                    default: d.ill = 1'b1;
                endcase
            end
            default: d.ill = 1'b1;
        endcase
        // Illegal words must not leak partially decoded fields.
        if (d.ill) begin
            d = '{alu: ALU_ADD, a_pc: 1'b0, b_imm: 1'b0, ill: 1'b1};
        end else begin
            d = d;
        end
        return d;
    endfunction

    logic             out_valid_r, skid_full_r, in_ready_r;
    dec_t             out_data_r, skid_data_r;
    logic [CNT_W-1:0] illegal_cnt_r;

    logic             accept_s;
    dec_t             dec_s;
    logic             out_valid_nxt_s, skid_full_nxt_s;
    dec_t             out_data_nxt_s, skid_data_nxt_s;
    logic [CNT_W-1:0] illegal_cnt_nxt_s;

    // Next-state for the output/skid pair and the illegal counter.
    always_comb begin
        accept_s          = in_valid & in_ready_r;
        dec_s             = decode(in_instr);
        out_valid_nxt_s   = out_valid_r;
        out_data_nxt_s    = out_data_r;
        skid_full_nxt_s   = skid_full_r;
        skid_data_nxt_s   = skid_data_r;
        illegal_cnt_nxt_s = illegal_cnt_r;
        if (!out_valid_r || out_ready) begin
            // in_ready is low whenever the skid holds a word, so accept and
            // skid_full are mutually exclusive here.
            if (skid_full_r) begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = skid_data_r;
                skid_full_nxt_s = 1'b0;
            end else if (accept_s) begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = dec_s;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_full_nxt_s = 1'b1;
                skid_data_nxt_s = dec_s;
            end else begin
                skid_full_nxt_s = skid_full_r;
            end
        end
        if (accept_s && dec_s.ill && (illegal_cnt_r != {CNT_W{1'b1}})) begin
            illegal_cnt_nxt_s = illegal_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            illegal_cnt_nxt_s = illegal_cnt_r;
        end
    end

    // State registers; in_ready is registered from the next skid state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            skid_full_r   <= 1'b0;
            skid_data_r   <= '0;
            in_ready_r    <= 1'b0;
            illegal_cnt_r <= '0;
        end else begin
            out_valid_r   <= out_valid_nxt_s;
            out_data_r    <= out_data_nxt_s;
            skid_full_r   <= skid_full_nxt_s;
            skid_data_r   <= skid_data_nxt_s;
            in_ready_r    <= !skid_full_nxt_s;
            illegal_cnt_r <= illegal_cnt_nxt_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign alu_cntrl   = out_data_r.alu;
    assign src_a_pc    = out_data_r.a_pc;
    assign src_b_imm   = out_data_r.b_imm;
    assign illegal     = out_data_r.ill;
    assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_alu_cntrl_decoder.sv
// Bench for alu_cntrl_decoder: a queue of in-flight results decoded by a
// table-driven reference model, checked every cycle against the DUT.
module tb_alu_cntrl_decoder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [3:0]  alu_cntrl;
    logic        src_a_pc, src_b_imm, illegal;
    logic [15:0] illegal_cnt;

    alu_cntrl_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_cntrl(alu_cntrl), .src_a_pc(src_a_pc), .src_b_imm(src_b_imm),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] alu;
        logic       apc;
        logic       bimm;
        logic       ill;
    } res_t;

    res_t        q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          n_out = 0;
    int          n_in = 0;
    logic [15:0] cnt_m = 16'd0;
    bit          last_in_fire;

    // f3 -> operation for the register/immediate arithmetic groups.
    logic [3:0] arith_tab [8] = '{4'd0, 4'd2, 4'd5, 4'd6, 4'd7, 4'd3, 4'd8, 4'd9};
    res_t       bad = '{alu: 4'd0, apc: 1'b0, bimm: 1'b0, ill: 1'b1};

    function automatic res_t ref_decode(logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        if (op == 7'h33) begin
            if (f7 == 7'h00) return '{arith_tab[f3], 1'b0, 1'b0, 1'b0};
            if (f7 == 7'h20 && f3 == 3'd0) return '{4'd1, 1'b0, 1'b0, 1'b0};
            if (f7 == 7'h20 && f3 == 3'd5) return '{4'd4, 1'b0, 1'b0, 1'b0};
            return bad;
        end
        if (op == 7'h13) begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? res_t'{4'd2, 1'b0, 1'b1, 1'b0} : bad;
            if (f3 == 3'd5) begin
                if (f7 == 7'h00) return '{4'd3, 1'b0, 1'b1, 1'b0};
                if (f7 == 7'h20) return '{4'd4, 1'b0, 1'b1, 1'b0};
                return bad;
            end
            return '{arith_tab[f3], 1'b0, 1'b1, 1'b0};
        end
        if (op == 7'h37) return '{4'd11, 1'b0, 1'b1, 1'b0};
        if (op == 7'h17) return '{4'd0, 1'b1, 1'b1, 1'b0};
        if (op == 7'h6F) return '{4'd12, 1'b1, 1'b0, 1'b0};
        if (op == 7'h67) return (f3 == 3'd0) ? res_t'{4'd12, 1'b1, 1'b0, 1'b0} : bad;
        if (op == 7'h03 || op == 7'h23) return '{4'd0, 1'b0, 1'b1, 1'b0};
        if (op == 7'h63) begin
            if (f3 == 3'd0 || f3 == 3'd1) return '{4'd1, 1'b0, 1'b0, 1'b0};
            if (f3 == 3'd4 || f3 == 3'd5) return '{4'd5, 1'b0, 1'b0, 1'b0};
            if (f3 == 3'd6 || f3 == 3'd7) return '{4'd6, 1'b0, 1'b0, 1'b0};
            return bad;
        end
        return bad;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] w = $urandom;
        logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
        w[6:0] = ops[$urandom_range(0, 8)];
        if (w[6:0] == 7'h33) begin
            if (w[30]) begin
                w[31:25] = 7'h20;
                w[14:12] = w[13] ? 3'd5 : 3'd0;
            end else begin
                w[31:25] = 7'h00;
            end
        end
        if (w[6:0] == 7'h13 && w[14:12] == 3'd1) w[31:25] = 7'h00;
        if (w[6:0] == 7'h13 && w[14:12] == 3'd5) w[31:25] = w[30] ? 7'h20 : 7'h00;
        if (w[6:0] == 7'h67) w[14:12] = 3'd0;
        if (w[6:0] == 7'h63 && w[14:13] == 2'b01) w[14] = 1'b1;
        return w;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: compare DUT against the model, then advance past the edge.
    task automatic step();
        bit   in_f, out_f;
        res_t r;
        in_f  = (in_valid && in_ready);
        out_f = (out_valid && out_ready);
        check("out_valid", out_valid, q.size() > 0);
        check("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) check("fields", {alu_cntrl, src_a_pc, src_b_imm, illegal}, q[0]);
        check("illegal_cnt", illegal_cnt, cnt_m);
        if (out_f && q.size() > 0) begin
            void'(q.pop_front());
            n_out++;
        end
        if (in_f) begin
            r = ref_decode(in_instr);
            q.push_back(r);
            n_in++;
            if (r.ill && cnt_m != 16'hFFFF) cnt_m++;
        end
        last_in_fire = in_f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_alu", alu_cntrl, 0);
        check("rst_flags", {src_a_pc, src_b_imm, illegal}, 0);
        check("rst_cnt", illegal_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        q.delete();
        cnt_m = 16'd0;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", in_ready, 1);
    endtask

    task automatic send_dir(string tag, logic [31:0] w, logic [6:0] exp);
        in_instr  = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check(tag, {alu_cntrl, src_a_pc, src_b_imm, illegal}, exp);
        step();
    endtask

    initial begin
        int n0, i0;
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
        do_reset();

        send_dir("add",  32'h003100B3, 7'h00);
        send_dir("sub",  32'h403100B3, 7'h08);
        send_dir("srai", 32'h40315093, 7'h22);
        send_dir("lui",  32'h123450B7, 7'h5A);
        send_dir("auipc",32'h00000097, 7'h06);
        send_dir("jal",  32'h000000EF, 7'h64);
        send_dir("bltu", 32'h0020E063, 7'h30);
        send_dir("ill_ones", 32'hFFFFFFFF, 7'h01);
        send_dir("ill_slli", 32'h02011093, 7'h01);
        check("cnt_two", illegal_cnt, 2);

        // Drive the counter to saturation, then once more.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 65533; i++) begin
            in_instr = $urandom & 32'hFFFF_FFFC;
            step();
        end
        in_valid = 1'b0;
        check("cnt_full", illegal_cnt, 16'hFFFF);
        send_dir("ill_sat", 32'h0000_0000, 7'h01);
        check("cnt_sat", illegal_cnt, 16'hFFFF);
        step();

        // Backpressure: fill both entries, hold a third word.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h003100B3;
        step();
        in_instr = 32'h403100B3;
        step();
        check("bp_in_ready", in_ready, 0);
        in_instr = rand_legal();
        repeat (3) step();
        n0 = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && (q.size() > 0 || in_valid); i++) begin
            step();
            if (last_in_fire) in_valid = 1'b0;
        end
        check("bp_drained", q.size(), 0);
        check("bp_count", n_out - n0, 3);

        // Streaming random legal words.
        n0 = n_out;
        i0 = n_in;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_instr = rand_legal();
            step();
        end
        in_valid = 1'b0;
        step();
        check("stream_in", n_in - i0, 100);
        check("stream_out", n_out - n0, 100);

        // Reset with both entries occupied.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = rand_legal();
        step();
        in_instr = 32'hFFFFFFFF;
        step();
        check("full_before_rst", in_ready, 0);
        do_reset();
        n0 = n_out;
        out_ready = 1'b1;
        repeat (4) step();
        check("rst_discard", n_out - n0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_cntrl_decoder.md
Name: alu_cntrl_decoder

Overview:
Instruction-side producer of the AluCntrl code consumed by the ALU. It accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes opcode/funct3/funct7 into an AluCntrl value plus operand-select flags. Results are delivered through a registered, two-entry elastic output: an output register plus a skid register. It sits between instruction fetch/issue and the ALU datapath. It also keeps a saturating count of illegal encodings.

Parameters:
CNT_W, 16, width of the illegal-instruction counter (saturates at 2^CNT_W-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  instruction word valid
in_ready  out  1  decoder can accept a word this cycle
in_instr  in  32  RV32I instruction word
out_valid  out  1  decoded result valid
out_ready  in  1  ALU side accepts result
alu_cntrl  out  4  AluCntrl code: ADD=0 SUB=1 SHIFT_LL=2 SHIFT_RL=3 SHIFT_RA=4 SET_LT=5 SET_LTU=6 XOR=7 OR=8 AND=9 PASS_A=10 PASS_B=11 PC_INC=12
src_a_pc  out  1  operand A is PC, not rs1
src_b_imm  out  1  operand B is immediate, not rs2
illegal  out  1  encoding not decodable
illegal_cnt  out  CNT_W  saturating count of accepted illegal words

Behaviour:
- Reset is synchronous and active-high, sampled on clk. While rst is high on an edge: out_valid=0, alu_cntrl=0 (ADD), src_a_pc=0, src_b_imm=0, illegal=0, illegal_cnt=0, skid empty. in_ready=0 while rst=1 and 1 on the first cycle after.
- Reset mid-transfer discards both buffered entries; no output is produced for them.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency is 1 cycle. A word accepted at edge N is presented at edge N if the output register is empty or draining; otherwise it goes to the skid register.
- in_ready = !skid_full, a registered signal. No combinational path from out_ready to in_ready.
- Order is preserved. No loss, no duplication. Output fields are held stable while out_valid=1 & out_ready=0.
- On output transfer with skid full: skid moves to the output register and in_ready returns to 1 next cycle.
- Simultaneous in-transfer and out-transfer with skid empty: the new word loads directly into the output register and out_valid stays 1.
- Decode is combinational on in_instr and registered at acceptance.
- OP (0110011), src_b_imm=0. funct7=0000000: f3 000 ADD, 001 SHIFT_LL, 010 SET_LT, 011 SET_LTU, 100 XOR, 101 SHIFT_RL, 110 OR, 111 AND. funct7=0100000: f3 000 SUB, f3 101 SHIFT_RA. Any other funct7/f3 pair is illegal.
- OP-IMM (0010011), src_b_imm=1. f3 000/010/011/100/110/111 map to ADD/SET_LT/SET_LTU/XOR/OR/AND.
  - f3 001: SHIFT_LL only if instr[31:25]=0.
  - f3 101: instr[31:25]=0000000 gives SHIFT_RL; 0100000 gives SHIFT_RA.
  - Anything else is illegal.
- LUI (0110111): PASS_B, src_b_imm=1.
- AUIPC (0010111): ADD, src_a_pc=1, src_b_imm=1.
- JAL (1101111) and JALR (1100111, f3=000 required): PC_INC, src_a_pc=1.
- LOAD (0000011) and STORE (0100011): ADD, src_b_imm=1. Per-f3 legality is not checked here.
- BRANCH (1100011), src_b_imm=0: f3 000/001 SUB; 100/101 SET_LT; 110/111 SET_LTU; 010/011 illegal.
- Any other opcode, including instr[1:0]!=11, is illegal.
- Illegal result fields: alu_cntrl=ADD, src_a_pc=0, src_b_imm=0, illegal=1.
- illegal_cnt increments by 1 on each accepted illegal word, at acceptance rather than at output. It saturates at all-ones and never wraps.

Test Plan:
- Reset, then in_valid=1 in_instr=0x003100B3 (add), out_ready=1 -> next cycle out_valid=1 alu_cntrl=0 src_b_imm=0 illegal=0. 0x403100B3 -> alu_cntrl=1 (SUB).
- 0x40315093 (srai) -> alu_cntrl=4 src_b_imm=1. 0x123450B7 (lui) -> alu_cntrl=11 src_b_imm=1. 0x00000097 (auipc) -> alu_cntrl=0 src_a_pc=1 src_b_imm=1. 0x000000EF (jal) -> alu_cntrl=12 src_a_pc=1. 0x0020E063 (bltu) -> alu_cntrl=6.
- Illegal 0xFFFFFFFF and 0x02011093 (slli shamt 32) -> illegal=1 alu_cntrl=0 each, illegal_cnt=2. Preload the counter to 0xFFFF via 65535 illegal words, send one more -> stays 0xFFFF.
- Backpressure: out_ready=0, send add then sub back-to-back -> in_ready=0 the cycle after the second accept and the third word is held. Raise out_ready -> add then sub then the third word, in order, each appearing exactly once.
- Streaming: in_valid=1 and out_ready=1 continuously for 100 random legal words -> one result per cycle after 1-cycle latency, in_ready never drops.
- Assert rst for one cycle with both entries full -> out_valid=0, illegal_cnt=0, in_ready=1 the following cycle, buffered words never appear.
